// File: rtl/frag_regfile_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frag_regfile_mp_if                                            |
// | Purpose  : Bundles the write, read and scoreboard signals of the         |
// |            multi-port register file into a single interface.             |
// | Ports    : master = issue/writeback side (drives addresses, data and     |
// |            scoreboard controls; observes read data, busy flags, count)   |
// |            slave  = register file side.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface frag_regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 3,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                sb_flush;
  logic [CW-1:0]       busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_cnt
  );
endinterface
`default_nettype wire

// File: rtl/frag_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frag_regfile_mp                                               |
// | Purpose  : Parametrised multi-port integer register file with optional   |
// |            write-to-read bypass and a per-register pending-write         |
// |            scoreboard used by issue logic for RAW hazard detection.      |
// | Ports    : sys_clk   - clock, all state updates on rising edge           |
// |            sys_arstn - asynchronous active-low reset                     |
// |            bus       - frag_regfile_mp_if.slave: NWR write ports,        |
// |                        NRD combinational read ports with busy flags,     |
// |                        scoreboard set/flush and registered busy count    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module frag_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 3,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             sys_clk,
  input  logic             sys_arstn,
  frag_regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt;

  // True when the address refers to the hardwired zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register array. Ports are visited in ascending order, so the last
  // non-blocking assignment (highest-index port) wins on a collision.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (bus.wr_en[k] && !is_zero_reg(bus.wr_addr[k*AW +: AW]))
          regs[bus.wr_addr[k*AW +: AW]] <= bus.wr_data[k*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: retire on write, then set (set wins a race with
  // a retiring write), then flush overrides everything.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (bus.wr_en[k]) busy_nxt[bus.wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (bus.sb_set_en && !is_zero_reg(bus.sb_set_addr))
      busy_nxt[bus.sb_set_addr] = 1'b1;
    if (bus.sb_flush) busy_nxt = '0;

    // Count is a popcount of the next state, never an increment, so
    // collisions and races cannot make it drift.
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      busy  <= '0;
      cnt_r <= '0;
    end else begin
      busy  <= busy_nxt;
      cnt_r <= cnt_nxt;
    end
  end

  assign bus.busy_cnt = cnt_r;

  // Read ports: all identical and independent.
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            hit;
    logic            bsy;

    assign addr = bus.rd_addr[j*AW +: AW];

    always_comb begin
      data = regs[addr];
      hit  = 1'b0;
      if (BYPASS != 0) begin
        // Ascending scan: highest-index matching write port ends up selected.
        for (int k = 0; k < NWR; k++) begin
          if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] == addr)) begin
            data = bus.wr_data[k*XLEN +: XLEN];
            hit  = 1'b1;
          end
        end
      end
      // A write landing this cycle resolves the hazard for a bypassing read.
      bsy = busy[addr] & ~hit;
      if (is_zero_reg(addr)) begin
        data = '0;
        bsy  = 1'b0;
      end
      // Outputs are quiet for the whole reset window, even with writes driven.
      if (!sys_arstn) begin
        data = '0;
        bsy  = 1'b0;
      end
    end

    assign bus.rd_data[j*XLEN +: XLEN] = data;
    assign bus.rd_busy[j]              = bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_frag_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_frag_regfile_mp                                            |
// | Purpose  : Directed self-checking bench for frag_regfile_mp. Two DUTs    |
// |            share one stimulus: dut_b (BYPASS=1) and dut_n (BYPASS=0).    |
// | Ports    : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_frag_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic sys_clk = 1'b0;
  logic sys_arstn;
  always #5 sys_clk = ~sys_clk;

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                sb_flush;

  frag_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_b ();
  frag_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_n ();

  assign bus_b.wr_en = wr_en;       assign bus_n.wr_en = wr_en;
  assign bus_b.wr_addr = wr_addr;   assign bus_n.wr_addr = wr_addr;
  assign bus_b.wr_data = wr_data;   assign bus_n.wr_data = wr_data;
  assign bus_b.rd_addr = rd_addr;   assign bus_n.rd_addr = rd_addr;
  assign bus_b.sb_set_en = sb_set_en;     assign bus_n.sb_set_en = sb_set_en;
  assign bus_b.sb_set_addr = sb_set_addr; assign bus_n.sb_set_addr = sb_set_addr;
  assign bus_b.sb_flush = sb_flush;       assign bus_n.sb_flush = sb_flush;

  frag_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                    .BYPASS(1), .ZERO_REG(1)) dut_b (
    .sys_clk  (sys_clk),
    .sys_arstn(sys_arstn),
    .bus      (bus_b.slave)
  );

  frag_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                    .BYPASS(0), .ZERO_REG(1)) dut_n (
    .sys_clk  (sys_clk),
    .sys_arstn(sys_arstn),
    .bus      (bus_n.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_flush = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = a;
    wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    rd_addr[j*AW +: AW] = a;
  endtask

  task automatic sb_set(input logic [AW-1:0] a);
    sb_set_en = 1'b1;
    sb_set_addr = a;
  endtask

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_arstn = 1'b0;
    idle();
    rd_addr = '0;

    // Reset state, with a write driven to prove outputs stay quiet.
    wr(0, 5'd5, 32'hCAFE_F00D);
    set_rd(0, 5'd5);
    #2;
    check("rst_rd0",   bus_b.rd_data[31:0], 64'h0);
    check("rst_busy",  bus_b.rd_busy,       64'h0);
    check("rst_cnt",   bus_b.busy_cnt,      64'h0);
    idle();
    @(negedge sys_clk);
    sys_arstn = 1'b1;
    step();

    // Reset test: write x5 and mark it pending in the same cycle.
    wr(0, 5'd5, 32'hDEAD_BEEF);
    sb_set(5'd5);
    step();
    idle();
    set_rd(0, 5'd5);
    #2;
    check("x5_data",   bus_b.rd_data[31:0], 64'hDEAD_BEEF);
    check("x5_busy",   bus_b.rd_busy[0],    64'h1);
    check("x5_cnt",    bus_b.busy_cnt,      64'd1);
    #1;
    sys_arstn = 1'b0;
    #1;
    check("arst_data", bus_b.rd_data[31:0], 64'h0);
    check("arst_busy", bus_b.rd_busy[0],    64'h0);
    check("arst_cnt",  bus_b.busy_cnt,      64'h0);
    wr(1, 5'd5, 32'h1234_5678);
    sb_set(5'd5);
    #1;
    check("arst_byp",  bus_b.rd_data[31:0], 64'h0);
    step();
    idle();
    @(negedge sys_clk);
    sys_arstn = 1'b1;
    step();
    #2;
    check("post_rst_x5",  bus_b.rd_data[31:0], 64'h0);
    check("post_rst_cnt", bus_b.busy_cnt,      64'h0);

    // Zero register: writes and scoreboard sets to x0 are dropped.
    wr(0, 5'd0, 32'hFFFF_FFFF);
    sb_set(5'd0);
    set_rd(0, 5'd0);
    #2;
    check("x0_byp",    bus_b.rd_data[31:0], 64'h0);
    check("x0_busy_c", bus_b.rd_busy[0],    64'h0);
    step();
    idle();
    #2;
    check("x0_data",   bus_b.rd_data[31:0], 64'h0);
    check("x0_busy",   bus_b.rd_busy[0],    64'h0);
    check("x0_cnt",    bus_b.busy_cnt,      64'h0);

    // Collision: both ports write x7, higher port wins.
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    set_rd(1, 5'd7);
    #2;
    check("col_byp",   bus_b.rd_data[63:32], 64'h22);
    check("col_nobyp", bus_n.rd_data[63:32], 64'h0);
    step();
    idle();
    #2;
    check("col_st_b",  bus_b.rd_data[63:32], 64'h22);
    check("col_st_n",  bus_n.rd_data[63:32], 64'h22);

    // Scoreboard: set x3, observe, then retire it with a write.
    sb_set(5'd3);
    set_rd(2, 5'd3);
    step();
    idle();
    #2;
    check("sb_busy",   bus_b.rd_busy[2],  64'h1);
    check("sb_cnt",    bus_b.busy_cnt,    64'd1);
    step();
    wr(0, 5'd3, 32'h33);
    #2;
    check("sb_byp_busy",   bus_b.rd_busy[2],     64'h0);
    check("sb_byp_data",   bus_b.rd_data[95:64], 64'h33);
    check("sb_nobyp_busy", bus_n.rd_busy[2],     64'h1);
    check("sb_cnt_hold",   bus_b.busy_cnt,       64'd1);
    step();
    idle();
    #2;
    check("sb_clr_cnt",  bus_b.busy_cnt,   64'd0);
    check("sb_clr_busy", bus_n.rd_busy[2], 64'h0);

    // Set/clear race on x9: the set wins, the data is still written.
    wr(1, 5'd9, 32'h99);
    sb_set(5'd9);
    step();
    idle();
    set_rd(0, 5'd9);
    #2;
    check("race_busy", bus_b.rd_busy[0],    64'h1);
    check("race_cnt",  bus_b.busy_cnt,      64'd1);
    check("race_data", bus_n.rd_data[31:0], 64'h99);
    wr(0, 5'd9, 32'h9A);
    step();
    idle();
    #2;
    check("race_ret_cnt", bus_b.busy_cnt, 64'd0);

    // Flush: three pending registers, then flush with a competing set.
    sb_set(5'd1);
    step();
    sb_set(5'd2);
    step();
    sb_set(5'd4);
    step();
    idle();
    set_rd(0, 5'd1);
    #2;
    check("fl_cnt3",  bus_b.busy_cnt,   64'd3);
    check("fl_busy1", bus_b.rd_busy[0], 64'h1);
    sb_flush = 1'b1;
    sb_set(5'd6);
    wr(0, 5'd10, 32'hAB);
    step();
    idle();
    set_rd(1, 5'd6);
    set_rd(2, 5'd10);
    #2;
    check("fl_cnt0",   bus_b.busy_cnt,       64'd0);
    check("fl_busy6",  bus_b.rd_busy[1],     64'h0);
    check("fl_busy1c", bus_b.rd_busy[0],     64'h0);
    check("fl_wrdata", bus_n.rd_data[95:64], 64'hAB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/frag_regfile_mp.md
# frag_regfile_mp

Parametrised multi-port integer register file for the RISC-V core, the successor to the current 2-read/1-write register file. It sits between decode/issue (read ports, scoreboard set) and writeback (write ports). It adds a configurable number of read and write ports, optional write-to-read bypass, and a per-register pending-write scoreboard that issue logic uses to detect RAW hazards on out-of-order or multi-cycle writebacks.

## Interface
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers, power of two, ≥ 2
- NRD, 3, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- ZERO_REG, 1, 1 = register 0 hardwired to zero (writes and scoreboard sets ignored)
- AW (local), clog2(NREG), register address width
- sys_clk  input  1  clock, all state updates on rising edge
- sys_arstn  input  1  reset, asynchronous, active-low
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*AW  port k address at bits [k*AW +: AW]
- wr_data  input  NWR*XLEN  port k data at bits [k*XLEN +: XLEN]
- rd_addr  input  NRD*AW  read port j address
- rd_data  output  NRD*XLEN  read port j data, combinational
- rd_busy  output  NRD  read port j register has a pending write
- sb_set_en  input  1  mark sb_set_addr as pending (instruction issued with destination)
- sb_set_addr  input  AW  destination register being marked
- sb_flush  input  1  clear every pending bit (pipeline flush)
- busy_cnt  output  clog2(NREG+1)  number of registers currently pending

## Operation
- Storage: NREG × XLEN registers; busy vector of NREG bits; busy_cnt register.
- Write: on rising edge, each port k with wr_en[k]=1 writes wr_data to wr_addr. If ZERO_REG=1 and wr_addr=0, write dropped.
- Write collision (two ports, same address, same cycle): highest-index port wins; no error flag.
- Read (combinational), priority per port j:
  - ZERO_REG=1 and rd_addr=0 → 0.
  - BYPASS=1 and any enabled write port targets rd_addr → data of highest-index matching port.
  - Otherwise stored value.
- Scoreboard clear: every enabled write port clears busy[wr_addr] at the edge (write completion retires the pending bit).
- Scoreboard set: sb_set_en sets busy[sb_set_addr]; dropped for address 0 when ZERO_REG=1.
- Set and clear on same address, same cycle: set wins (new producer issued while old one retires).
- sb_flush: clears all busy bits; overrides sb_set_en and clears in that cycle. Register contents still written.
- rd_busy[j] = busy[rd_addr_j], except forced 0 if BYPASS=1 and an enabled write port targets rd_addr_j in the same cycle, and forced 0 for address 0 when ZERO_REG=1.
- busy_cnt: registered; equals population count of busy vector after each edge (next-state popcount, not incremental), so collisions never drift it.

## Timing
- Reset (sys_arstn low, asynchronous): all registers 0, busy all 0, busy_cnt 0. While reset asserted, rd_data = 0 and rd_busy = 0 on all ports regardless of write inputs; writes and sets ignored.
- Reset release mid-operation: first rising edge after deassertion is the first active edge.
- Read latency: 0 cycles (combinational from rd_addr, wr_* and state).
- Write latency: value stored at edge; visible from stored path the next cycle, same cycle via bypass when BYPASS=1.
- busy set visible on rd_busy/busy_cnt the cycle after sb_set_en; clear visible the cycle after the write (same cycle on rd_busy when BYPASS=1).
- No stall/ready handshake; all inputs sampled every edge. All read ports independent and identical.

## Test plan
- Reset: write x5=0xDEADBEEF, set busy x5, assert sys_arstn low mid-cycle → rd_data=0, rd_busy=0, busy_cnt=0 immediately; after release read x5 → 0.
- Zero register: wr_en[0]=1 addr 0 data 0xFFFFFFFF, sb_set addr 0 → read x0 = 0, rd_busy=0, busy_cnt=0.
- Collision/bypass: ports 0 and 1 both write x7 (0x11, 0x22), read x7 same cycle → 0x22 (BYPASS=1), stored 0x22 next cycle; with BYPASS=0 same-cycle read returns old 0x0.
- Scoreboard: set x3 cycle 0 → rd_busy=1, busy_cnt=1 cycle 1; write x3 cycle 2 → rd_busy=0 same cycle (bypass), busy_cnt=0 cycle 3.
- Set/clear race: write x9 and sb_set x9 same cycle → busy[x9]=1 next cycle, busy_cnt=1, x9 holds written data.
- Flush: set x1, x2, x4 over 3 cycles (busy_cnt=3), then sb_flush with sb_set x6 → busy_cnt=0, rd_busy for x6 = 0.
